// File: rtl/div_unit.sv
// Radix-2 restoring DIV/DIVU unit producing {remainder, quotient} for HI/LO.
// Latency: done 33 cycles after start is accepted, 1 cycle for a zero divisor.
// Backpressure: holds IF..EX through stall_req while busy; annul abandons the op.
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  signed_div,
  input  logic [DATA_W-1:0]     opdata_a,
  input  logic [DATA_W-1:0]     opdata_b,
  input  logic                  annul,
  output logic                  stall_req,
  output logic                  done,
  output logic [2*DATA_W-1:0]   result
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   rem_q;
  logic [DATA_W-1:0]   quo_q;
  logic [DATA_W-1:0]   dvsr_q;
  logic                qneg_q;
  logic                rneg_q;

  logic                a_neg;
  logic                b_neg;
  logic [DATA_W-1:0]   a_abs;
  logic [DATA_W-1:0]   b_abs;
  logic [DATA_W:0]     trial;
  logic [DATA_W-1:0]   rem_nxt;
  logic [DATA_W-1:0]   quo_nxt;
  logic [DATA_W-1:0]   rem_fix;
  logic [DATA_W-1:0]   quo_fix;
  logic                last;

  always_comb begin
    a_neg = signed_div & opdata_a[DATA_W-1];
    b_neg = signed_div & opdata_b[DATA_W-1];
    a_abs = a_neg ? -opdata_a : opdata_a;
    b_abs = b_neg ? -opdata_b : opdata_b;

    // Shifted partial remainder is W+1 bits wide; the top bit of the difference is the borrow.
    trial = {rem_q, quo_q[DATA_W-1]} - {1'b0, dvsr_q};
    if (!trial[DATA_W]) begin
      rem_nxt = trial[DATA_W-1:0];
      quo_nxt = {quo_q[DATA_W-2:0], 1'b1};
    end else begin
      rem_nxt = {rem_q[DATA_W-2:0], quo_q[DATA_W-1]};
      quo_nxt = {quo_q[DATA_W-2:0], 1'b0};
    end

    rem_fix = rneg_q ? -rem_nxt : rem_nxt;
    quo_fix = qneg_q ? -quo_nxt : quo_nxt;
    last    = (cnt == CNT_W'(DATA_W-1));
  end

  // Dropping the stall in DONE lets EX advance so the same instruction is not re-issued.
  assign stall_req = (state == BUSY) | ((state == IDLE) & start & ~annul);
  assign done      = (state == DONE) & ~annul;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      cnt    <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvsr_q <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !annul) begin
            if (opdata_b != '0) begin
              rem_q  <= '0;
              quo_q  <= a_abs;
              dvsr_q <= b_abs;
              qneg_q <= a_neg ^ b_neg;
              rneg_q <= a_neg;
              cnt    <= '0;
              state  <= BUSY;
            end else begin
              result <= {opdata_a, {DATA_W{1'b1}}};
              state  <= DONE;
            end
          end
        end
        BUSY: begin
          if (annul) begin
            state <= IDLE;
          end else begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            cnt   <= cnt + 1'b1;
            if (last) begin
              result <= {rem_fix, quo_fix};
              state  <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random operands vs. an arithmetic model.
module tb_div_unit;

  logic        clk;
  logic        resetn;
  logic        start;
  logic        signed_div;
  logic [31:0] opdata_a;
  logic [31:0] opdata_b;
  logic        annul;
  logic        stall_req;
  logic        done;
  logic [63:0] result;

  int checks;
  int errors;

  div_unit #(.DATA_W(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .signed_div (signed_div),
    .opdata_a   (opdata_a),
    .opdata_b   (opdata_b),
    .annul      (annul),
    .stall_req  (stall_req),
    .done       (done),
    .result     (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic; SV '/' and '%' truncate toward zero.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Issue one divide with start held until the done cycle; checks stall profile, latency and result.
  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input string nm, input bit chain);
    logic [63:0] exp_res;
    logic [63:0] got;
    int exp_lat, done_at, stall_bad;
    exp_res   = ref_div(sgn, a, b);
    exp_lat   = (b == 32'd0) ? 1 : 33;
    done_at   = -1;
    stall_bad = 0;
    got       = '0;
    @(posedge clk); #1;
    start = 1'b1; signed_div = sgn; opdata_a = a; opdata_b = b; annul = 1'b0;
    @(negedge clk);
    if (stall_req !== 1'b1) stall_bad++;
    for (int i = 1; i <= 40 && done_at < 0; i++) begin
      @(posedge clk); #1;
      if (i < exp_lat) begin
        signed_div = 1'($urandom);
        opdata_a   = $urandom;
        opdata_b   = $urandom;
      end
      @(negedge clk);
      if (stall_req !== (i < exp_lat)) stall_bad++;
      if (done === 1'b1) begin
        done_at = i;
        got     = result;
      end
    end
    checks++;
    if (done_at !== exp_lat) begin
      errors++;
      $display("FAIL %s latency: done after %0d cycles, expected %0d", nm, done_at, exp_lat);
    end
    checks++;
    if (got !== exp_res) begin
      errors++;
      $display("FAIL %s result: got %h expected %h", nm, got, exp_res);
    end
    checks++;
    if (stall_bad != 0) begin
      errors++;
      $display("FAIL %s stall_req: %0d wrong cycles, expected 0", nm, stall_bad);
    end
    if (!chain) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || stall_req !== 1'b0) begin
        errors++;
        $display("FAIL %s after_done: done=%b stall_req=%b expected 0 0", nm, done, stall_req);
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; signed_div = 1'b0; opdata_a = '0; opdata_b = '0; annul = 1'b0;
    #12;
    checks++;
    if (done !== 1'b0 || stall_req !== 1'b0 || result !== 64'd0) begin
      errors++;
      $display("FAIL reset: done=%b stall_req=%b result=%h expected 0 0 0", done, stall_req, result);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  task automatic test_unsigned_basic();
    do_div(1'b0, 32'd100, 32'd7, "divu_100_7", 1'b0);
    do_div(1'b0, 32'hFFFF_FFFF, 32'd1, "divu_max_1", 1'b0);
    do_div(1'b0, 32'd5, 32'hFFFF_FFFF, "divu_small_big", 1'b0);
  endtask

  task automatic test_signed();
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, "div_m7_2", 1'b0);
    do_div(1'b1, 32'd7, 32'hFFFF_FFFE, "div_7_m2", 1'b0);
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1", 1'b0);
    do_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, "divu_min_m1", 1'b0);
    do_div(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, "div_m7_m2", 1'b0);
  endtask

  task automatic test_div_by_zero();
    do_div(1'b0, 32'h0000_1234, 32'd0, "divu_by_zero", 1'b0);
    do_div(1'b1, 32'hFFFF_FF00, 32'd0, "div_by_zero", 1'b0);
  endtask

  task automatic test_annul_busy();
    int early;
    early = 0;
    @(posedge clk); #1;
    start = 1'b1; signed_div = 1'b0; opdata_a = 32'hDEAD_BEEF; opdata_b = 32'd13; annul = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      annul = (i == 10);
      @(negedge clk);
      if (done === 1'b1) early++;
    end
    @(posedge clk); #1;
    start = 1'b0; annul = 1'b0;
    @(negedge clk);
    checks++;
    if (early != 0 || done !== 1'b0 || stall_req !== 1'b0) begin
      errors++;
      $display("FAIL annul_busy: early_done=%0d done=%b stall_req=%b expected 0 0 0", early, done, stall_req);
    end
    do_div(1'b0, 32'd9, 32'd3, "divu_9_3_after_annul", 1'b0);
  endtask

  task automatic test_annul_idle();
    @(posedge clk); #1;
    start = 1'b1; signed_div = 1'b0; opdata_a = 32'h55; opdata_b = 32'd0; annul = 1'b1;
    @(negedge clk);
    checks++;
    if (stall_req !== 1'b0) begin
      errors++;
      $display("FAIL annul_idle_stall: stall_req=%b expected 0", stall_req);
    end
    @(posedge clk); #1;
    start = 1'b0; annul = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL annul_idle_done: done=%b expected 0", done);
    end
  endtask

  task automatic test_reset_mid_busy();
    int pulses;
    pulses = 0;
    @(posedge clk); #1;
    start = 1'b1; signed_div = 1'b1; opdata_a = 32'h1234_5678; opdata_b = 32'd3; annul = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    resetn = 1'b0; start = 1'b0;
    #1;
    checks++;
    if (done !== 1'b0 || result !== 64'd0 || stall_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_busy: done=%b result=%h stall_req=%b expected 0 0 0", done, result, stall_req);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL reset_no_done: %0d done pulses, expected 0", pulses);
    end
  endtask

  task automatic test_back_to_back();
    do_div(1'b0, 32'd1000, 32'd10, "b2b_first", 1'b1);
    do_div(1'b1, 32'hFFFF_FC18, 32'd7, "b2b_second", 1'b1);
    do_div(1'b0, 32'd77, 32'd0, "b2b_zero", 1'b1);
    do_div(1'b0, 32'd123456, 32'd789, "b2b_last", 1'b0);
  endtask

  task automatic test_random();
    logic        sgn;
    logic [31:0] a, b;
    for (int n = 0; n < 24; n++) begin
      sgn = 1'($urandom);
      a   = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'($urandom_range(1, 16));
        1:       b = 32'd0;
        default: b = $urandom;
      endcase
      if (n % 5 == 0) a = 32'($urandom_range(0, 100));
      do_div(sgn, a, b, "random", 1'b0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_unsigned_basic();
    test_signed();
    test_div_by_zero();
    test_annul_busy();
    test_annul_idle();
    test_reset_mid_busy();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
